// File: rtl/framebuffer_arbiter_if.sv
// Signal bundle for framebuffer_arbiter: MCU command/pixel path, scanout port and RAM port.
// Optional: define FB_ARB_STATS_EN to add the stall_count signal.
interface framebuffer_arbiter_if #(
   parameter int ADDR_WIDTH  = 17,
   parameter int PIXEL_WIDTH = 12
);
   logic                   cmd_valid;
   logic [7:0]             cmd_data;
   logic                   cmd_ready;
   logic                   pixel_valid;
   logic [PIXEL_WIDTH-1:0] pixel_data;
   logic                   scan_req;
   logic [ADDR_WIDTH-1:0]  scan_addr;
   logic [PIXEL_WIDTH-1:0] scan_data;
   logic                   scan_valid;
   logic                   mem_en;
   logic                   mem_we;
   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic [PIXEL_WIDTH-1:0] mem_wdata;
   logic [PIXEL_WIDTH-1:0] mem_rdata;
   logic                   busy;
   logic                   overflow;
   logic                   cmd_error;
`ifdef FB_ARB_STATS_EN
   logic [15:0]            stall_count;
`endif

   modport slave (
      input  cmd_valid, cmd_data, pixel_valid, pixel_data, scan_req, scan_addr, mem_rdata,
      output cmd_ready, scan_data, scan_valid, mem_en, mem_we, mem_addr, mem_wdata,
             busy, overflow, cmd_error
`ifdef FB_ARB_STATS_EN
      , output stall_count
`endif
   );

   modport master (
      output cmd_valid, cmd_data, pixel_valid, pixel_data, scan_req, scan_addr, mem_rdata,
      input  cmd_ready, scan_data, scan_valid, mem_en, mem_we, mem_addr, mem_wdata,
             busy, overflow, cmd_error
`ifdef FB_ARB_STATS_EN
      , input stall_count
`endif
   );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout reads > fill engine > buffered MCU pixel writes.
// Optional: define FB_ARB_STATS_EN to count cycles where pending writes are held off by scanout.
module framebuffer_arbiter #(
   parameter int ADDR_WIDTH  = 17,
   parameter int PIXEL_WIDTH = 12,
   parameter int FB_PIXELS   = 76800,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                system_clock,
   input  logic                reset_n,
   framebuffer_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = ADDR_WIDTH + PIXEL_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_PIXELS - 1);
   localparam logic [PTR_W:0]        FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CUR0    = 3'd1;
   localparam logic [2:0] S_CUR1    = 3'd2;
   localparam logic [2:0] S_CUR2    = 3'd3;
   localparam logic [2:0] S_FILL0   = 3'd4;
   localparam logic [2:0] S_FILL1   = 3'd5;
   localparam logic [2:0] S_FILLING = 3'd6;

   logic [2:0]             state_q, state_d;
   logic [7:0]             arg0_q, arg0_d, arg1_q, arg1_d;
   logic [PIXEL_WIDTH-1:0] color_q, color_d;
   logic [ADDR_WIDTH-1:0]  fill_addr_q, fill_addr_d;
   logic [ADDR_WIDTH-1:0]  cursor_q, cursor_d;
   logic [ENT_W-1:0]       fifo_q [FIFO_DEPTH];
   logic [ENT_W-1:0]       fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]         count_q, count_d;
   logic                   mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [PIXEL_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                   scan_valid_q, scan_valid_d;
   logic                   busy_q, busy_d, overflow_q, overflow_d;
   logic                   cmd_error_q, cmd_error_d, cmd_ready_q, cmd_ready_d;

   logic                   filling_s, fifo_empty_s, fifo_full_s;
   logic                   fill_grant_s, deq_s, enq_s, cursor_load_s;
   logic [ADDR_WIDTH-1:0]  cursor_arg_s;

   assign filling_s    = (state_q == S_FILLING);
   assign fifo_empty_s = (count_q == '0);
   assign fifo_full_s  = (count_q == FULL_CNT);
   assign cursor_arg_s = ADDR_WIDTH'({bus.cmd_data, arg1_q, arg0_q});

   // Command parser: cursor load (3 LE address bytes) and fill (2 color bytes).
   always_comb begin
      state_d       = state_q;
      arg0_d        = arg0_q;
      arg1_d        = arg1_q;
      color_d       = color_q;
      fill_addr_d   = fill_addr_q;
      cursor_load_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && (bus.cmd_data == 8'h01)) state_d = S_CUR0;
            else if (bus.cmd_valid && (bus.cmd_data == 8'h02)) state_d = S_FILL0;
            else state_d = S_IDLE;
         end
         S_CUR0: begin
            if (bus.cmd_valid) begin arg0_d = bus.cmd_data; state_d = S_CUR1; end
            else state_d = S_CUR0;
         end
         S_CUR1: begin
            if (bus.cmd_valid) begin arg1_d = bus.cmd_data; state_d = S_CUR2; end
            else state_d = S_CUR1;
         end
         S_CUR2: begin
            if (bus.cmd_valid) begin cursor_load_s = 1'b1; state_d = S_IDLE; end
            else state_d = S_CUR2;
         end
         S_FILL0: begin
            if (bus.cmd_valid) begin arg0_d = bus.cmd_data; state_d = S_FILL1; end
            else state_d = S_FILL0;
         end
         S_FILL1: begin
            if (bus.cmd_valid) begin
               color_d     = PIXEL_WIDTH'({arg0_q, bus.cmd_data[3:0]});
               fill_addr_d = '0;
               state_d     = S_FILLING;
            end else begin
               state_d = S_FILL1;
            end
         end
         S_FILLING: begin
            if (fill_grant_s && (fill_addr_q == LAST_ADDR)) begin
               fill_addr_d = '0;
               state_d     = S_IDLE;
            end else if (fill_grant_s) begin
               fill_addr_d = fill_addr_q + ADDR_WIDTH'(1);
            end else begin
               fill_addr_d = fill_addr_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Port scheduling: scanout always wins, then an active fill, then the FIFO head.
   always_comb begin
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      fill_grant_s = 1'b0;
      deq_s        = 1'b0;
      if (bus.scan_req) begin
         mem_en_d   = 1'b1;
         mem_addr_d = bus.scan_addr;
      end else if (filling_s) begin
         mem_en_d     = 1'b1;
         mem_we_d     = 1'b1;
         mem_addr_d   = fill_addr_q;
         mem_wdata_d  = color_q;
         fill_grant_s = 1'b1;
      end else if (!fifo_empty_s) begin
         mem_en_d    = 1'b1;
         mem_we_d    = 1'b1;
         mem_addr_d  = fifo_q[rd_ptr_q][ENT_W-1 -: ADDR_WIDTH];
         mem_wdata_d = fifo_q[rd_ptr_q][PIXEL_WIDTH-1:0];
         deq_s       = 1'b1;
      end else begin
         mem_en_d = 1'b0;
      end
   end

   // Pixel FIFO and write cursor; a full FIFO still accepts when its head leaves this cycle.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cursor_d = cursor_q;
      enq_s    = bus.pixel_valid && (!fifo_full_s || deq_s);
      if (enq_s) begin
         fifo_d[wr_ptr_q] = {cursor_q, bus.pixel_data};
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else rd_ptr_d = rd_ptr_q;
      count_d = count_q + {{PTR_W{1'b0}}, enq_s} - {{PTR_W{1'b0}}, deq_s};
      if (cursor_load_s) cursor_d = cursor_arg_s;
      else if (enq_s) cursor_d = (cursor_q == LAST_ADDR) ? '0 : cursor_q + ADDR_WIDTH'(1);
      else cursor_d = cursor_q;
   end

   // Status outputs are registered from next-state so they line up with the state they describe.
   always_comb begin
      scan_valid_d = mem_en_q && !mem_we_q;
      overflow_d   = overflow_q || (bus.pixel_valid && !enq_s);
      cmd_error_d  = cmd_error_q || (bus.cmd_valid && filling_s);
      busy_d       = (state_d == S_FILLING) || (count_d != '0);
      cmd_ready_d  = (state_d != S_FILLING);
   end

   // State registers.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         arg0_q       <= 8'h00;
         arg1_q       <= 8'h00;
         color_q      <= '0;
         fill_addr_q  <= '0;
         cursor_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         scan_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
         cmd_error_q  <= 1'b0;
         cmd_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         arg0_q       <= arg0_d;
         arg1_q       <= arg1_d;
         color_q      <= color_d;
         fill_addr_q  <= fill_addr_d;
         cursor_q     <= cursor_d;
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         scan_valid_q <= scan_valid_d;
         busy_q       <= busy_d;
         overflow_q   <= overflow_d;
         cmd_error_q  <= cmd_error_d;
         cmd_ready_q  <= cmd_ready_d;
      end
   end

   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.scan_valid = scan_valid_q;
   // RAM data arrives a cycle after the read strobe, so it is forwarded rather than re-registered.
   assign bus.scan_data  = scan_valid_q ? bus.mem_rdata : '0;
   assign bus.busy       = busy_q;
   assign bus.overflow   = overflow_q;
   assign bus.cmd_error  = cmd_error_q;
   assign bus.cmd_ready  = cmd_ready_q;

`ifdef FB_ARB_STATS_EN
   logic [15:0] stall_count_q, stall_count_d;
   logic        stall_s;

   assign stall_s = bus.scan_req && (filling_s || !fifo_empty_s);

   // Saturating count of cycles where a pending write lost the port to scanout.
   always_comb begin
      if (stall_s && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
      else stall_count_d = stall_count_q;
   end

   // Stall counter register.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) stall_count_q <= 16'h0000;
      else stall_count_q <= stall_count_d;
   end

   assign bus.stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Self-checking bench for framebuffer_arbiter: directed command sequences plus random
// scan/pixel traffic, checked cycle by cycle against a queue-based reference model.
module tb_framebuffer_arbiter;
   localparam int AW   = 17;
   localparam int PW   = 12;
   localparam int NPIX = 76800;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [PW-1:0] d;
   } ent_t;

   logic system_clock = 1'b0;
   logic reset_n      = 1'b0;
   logic init_req     = 1'b0;
   logic [PW-1:0] ram [NPIX];
   logic [PW-1:0] rdata_r = '0;

   framebuffer_arbiter_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) bus ();

   framebuffer_arbiter #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .FB_PIXELS(NPIX), .FIFO_DEPTH(4)) dut (
      .system_clock (system_clock),
      .reset_n      (reset_n),
      .bus          (bus)
   );

   always #5 system_clock = ~system_clock;

   function automatic logic [PW-1:0] pat(input int i);
      return PW'(i * 37 + 5);
   endfunction

   // Framebuffer RAM: one port, registered read data.
   assign bus.mem_rdata = rdata_r;
   always @(posedge system_clock) begin
      if (init_req) begin
         for (int i = 0; i < NPIX; i++) ram[i] <= pat(i);
      end else if (bus.mem_en && bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end else if (bus.mem_en) begin
         rdata_r <= ram[bus.mem_addr];
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [PW-1:0] m_img [NPIX];
   ent_t          m_q [$];
   int            m_cursor, m_fill, m_need, m_kind, m_stall;
   bit            m_filling, m_ovf, m_cerr, p_sreq;
   int            p_saddr;
   logic [PW-1:0] m_color;
   logic [7:0]    m_args [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_args.delete();
      m_cursor = 0; m_fill = 0; m_need = 0; m_kind = 0; m_stall = 0;
      m_filling = 1'b0; m_ovf = 1'b0; m_cerr = 1'b0; p_sreq = 1'b0; p_saddr = 0;
      m_color = '0;
   endtask

   task automatic apply_reset();
      bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00; bus.pixel_valid = 1'b0;
      bus.pixel_data = '0; bus.scan_req = 1'b0; bus.scan_addr = '0;
      reset_n = 1'b0;
      #1;
      chk("rst_mem_en", 32'(bus.mem_en), 32'(0));
      chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
      chk("rst_scan_valid", 32'(bus.scan_valid), 32'(0));
      chk("rst_scan_data", 32'(bus.scan_data), 32'(0));
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_overflow", 32'(bus.overflow), 32'(0));
      chk("rst_cmd_error", 32'(bus.cmd_error), 32'(0));
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
`ifdef FB_ARB_STATS_EN
      chk("rst_stall_count", 32'(bus.stall_count), 32'(0));
`endif
      model_reset();
      repeat (2) @(posedge system_clock);
      #1;
      chk("rst_hold_mem_en", 32'(bus.mem_en), 32'(0));
      reset_n = 1'b1;
   endtask

   // One clock of stimulus, model update and output comparison.
   task automatic cycle(input logic sreq, input int saddr, input logic pv, input logic [PW-1:0] pd,
                        input logic cv, input logic [7:0] cd);
      logic e_sv, e_en, e_we;
      logic [PW-1:0] e_sd, e_wd;
      int e_addr;
      bit filling_now;
      ent_t e;
      bus.scan_req = sreq; bus.scan_addr = AW'(saddr);
      bus.pixel_valid = pv; bus.pixel_data = pd;
      bus.cmd_valid = cv; bus.cmd_data = cd;

      e_sv = p_sreq;
      e_sd = p_sreq ? m_img[p_saddr] : '0;
      filling_now = m_filling;
      if (sreq && (filling_now || m_q.size() > 0) && m_stall < 65535) m_stall++;
      e_en = 1'b0; e_we = 1'b0; e_addr = 0; e_wd = '0;
      if (sreq) begin
         e_en = 1'b1; e_addr = saddr;
      end else if (filling_now) begin
         e_en = 1'b1; e_we = 1'b1; e_addr = m_fill; e_wd = m_color;
         m_img[m_fill] = m_color;
         if (m_fill == NPIX - 1) begin m_filling = 1'b0; m_fill = 0; end
         else m_fill++;
      end else if (m_q.size() > 0) begin
         e = m_q.pop_front();
         e_en = 1'b1; e_we = 1'b1; e_addr = int'(e.a); e_wd = e.d;
         m_img[e.a] = e.d;
      end
      if (pv) begin
         if (m_q.size() < 4) begin
            m_q.push_back({AW'(m_cursor), pd});
            m_cursor = (m_cursor == NPIX - 1) ? 0 : m_cursor + 1;
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (cv) begin
         if (filling_now) begin
            m_cerr = 1'b1;
         end else if (m_need == 0) begin
            if (cd == 8'h01) begin m_kind = 1; m_need = 3; m_args.delete(); end
            else if (cd == 8'h02) begin m_kind = 2; m_need = 2; m_args.delete(); end
         end else begin
            m_args.push_back(cd);
            m_need--;
            if (m_need == 0 && m_kind == 1) begin
               m_cursor = int'({m_args[2][0], m_args[1], m_args[0]});
            end else if (m_need == 0) begin
               m_color = {m_args[0], m_args[1][3:0]};
               m_filling = 1'b1;
               m_fill = 0;
            end
         end
      end
      p_sreq = sreq; p_saddr = saddr;

      @(posedge system_clock);
      #1;
      bus.scan_req = 1'b0; bus.pixel_valid = 1'b0; bus.cmd_valid = 1'b0;
      chk("mem_en", 32'(bus.mem_en), 32'(e_en));
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      if (e_en) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
      chk("scan_valid", 32'(bus.scan_valid), 32'(e_sv));
      chk("scan_data", 32'(bus.scan_data), 32'(e_sd));
      chk("busy", 32'(bus.busy), 32'(m_filling || (m_q.size() > 0)));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_filling));
      chk("cmd_error", 32'(bus.cmd_error), 32'(m_cerr));
`ifdef FB_ARB_STATS_EN
      chk("stall_count", 32'(bus.stall_count), 32'(m_stall));
`endif
   endtask

   task automatic cmd(input logic [7:0] b);
      cycle(1'b0, 0, 1'b0, '0, 1'b1, b);
   endtask

   task automatic pix(input logic [PW-1:0] p);
      cycle(1'b0, 0, 1'b1, p, 1'b0, 8'h00);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, '0, 1'b0, 8'h00);
   endtask

   initial begin
      int guard;
      for (int i = 0; i < NPIX; i++) m_img[i] = pat(i);
      model_reset();
      init_req = 1'b1;
      @(posedge system_clock);
      #1;
      init_req = 1'b0;
      apply_reset();

      // Cursor to 0x10, two pixels
      cmd(8'h01); cmd(8'h10); cmd(8'h00); cmd(8'h00);
      pix(12'hABC); pix(12'h123);
      idle(3);
      chk("ram_0x10", 32'(ram[16]), 32'h0ABC);
      chk("ram_0x11", 32'(ram[17]), 32'h0123);
      pix(12'h456);
      idle(2);
      chk("ram_0x12", 32'(ram[18]), 32'h0456);

      // Cursor wrap at the last framebuffer word
      cmd(8'h01); cmd(8'hFF); cmd(8'h2B); cmd(8'h01);
      pix(12'h9A1); pix(12'h9A2);
      idle(3);
      chk("ram_last", 32'(ram[NPIX-1]), 32'h09A1);
      chk("ram_wrap0", 32'(ram[0]), 32'h09A2);
      chk("no_overflow", 32'(bus.overflow), 32'(0));

      // Scan holds the port while five pixels arrive
      for (int i = 0; i < 12; i++)
         cycle(1'b1, $urandom_range(NPIX - 1, 0), (i >= 1 && i <= 5), PW'(12'h100 + i), 1'b0, 8'h00);
      idle(6);
      chk("overflow_set", 32'(bus.overflow), 32'(1));
      chk("ram_fifo1", 32'(ram[1]), 32'h0101);
      chk("ram_fifo4", 32'(ram[4]), 32'h0104);

      // Random scan and pixel traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(1, 0) == 1, $urandom_range(NPIX - 1, 0),
               $urandom_range(9, 0) < 4, PW'($urandom), 1'b0, 8'h00);
      idle(6);

      // Full-screen fill with a pixel and a stray command byte arriving mid-fill
      cmd(8'h01); cmd(8'h05); cmd(8'h00); cmd(8'h00);
      cmd(8'h02); cmd(8'hF0); cmd(8'h0F);
      chk("fill_cmd_ready", 32'(bus.cmd_ready), 32'(0));
      guard = 0;
      while ((m_filling || m_q.size() > 0) && guard < 80000) begin
         cycle((guard < 200) && ($urandom_range(3, 0) == 0), $urandom_range(NPIX - 1, 0),
               guard == 10, 12'h777, guard == 12, 8'h55);
         guard++;
      end
      chk("fill_complete", 32'(bus.busy), 32'(0));
      idle(2);
      chk("fill_ram5", 32'(ram[5]), 32'h0777);
      chk("fill_ram6", 32'(ram[6]), 32'h0F0F);
      chk("fill_ram_last", 32'(ram[NPIX-1]), 32'h0F0F);
      chk("fill_cmd_error", 32'(bus.cmd_error), 32'(1));

      // Reset in the middle of a fill
      cmd(8'h02); cmd(8'h12); cmd(8'h03);
      guard = 0;
      while (m_fill != 100 && guard < 1000) begin
         idle(1);
         guard++;
      end
      chk("midfill_reached", 32'(bus.mem_addr), 32'(99));
      apply_reset();
      idle(5);
      chk("midfill_ram98", 32'(ram[98]), 32'h0123);
      chk("midfill_ram99", 32'(ram[99]), 32'h0F0F);
      chk("midfill_ram100", 32'(ram[100]), 32'h0F0F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
